// File: rtl/bcd_seg_scan_if.sv
// Bundle between the binary-to-BCD converter / display control and the 7-segment scanner.
//   in_valid   : single-cycle strobe, the digits are sampled when it is high
//   in_hundred : hundreds digit (0..5 in practice, 3 bits wide)
//   in_ten     : tens digit
//   in_unit    : units digit
//   disp_en    : display enable, low forces the scanner idle
//   seg        : shared segment bus {g,f,e,d,c,b,a}, active high
//   an         : one-hot digit enable, [2]=hundreds [1]=tens [0]=units
//   frame_done : one-cycle pulse in the last cycle of the units slot
// master drives the digit/enable side, slave is the scanner.
interface bcd_seg_scan_if;
  logic       in_valid;
  logic [2:0] in_hundred;
  logic [3:0] in_ten;
  logic [3:0] in_unit;
  logic       disp_en;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;

  modport master (
    output in_valid, in_hundred, in_ten, in_unit, disp_en,
    input  seg, an, frame_done
  );

  modport slave (
    input  in_valid, in_hundred, in_ten, in_unit, disp_en,
    output seg, an, frame_done
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// Three-digit 7-segment scanner. Captures hundreds/tens/units on bus.in_valid and
// time-multiplexes them onto one segment bus, SCAN_DIV cycles per digit, with a
// frame_done pulse in the last units cycle.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : bcd_seg_scan_if.slave (digit inputs, disp_en, seg/an/frame_done outputs)
// Parameters:
//   SCAN_DIV : cycles each digit stays enabled, 1..255
// Optional feature: define BCD_SEG_BLANK_EN for leading-zero blanking of the
// hundreds and tens slots; the units slot is never blanked.
module bcd_seg_scan #(
  parameter int unsigned SCAN_DIV = 4
) (
  input logic             clk,
  input logic             rst_n,
  bcd_seg_scan_if.slave   bus
);

  typedef enum logic {StIdle, StScan} state_e;
  typedef enum logic [1:0] {SlotHund = 2'd0, SlotTen = 2'd1, SlotUnit = 2'd2} slot_e;

  localparam logic [7:0] CntLast = 8'(SCAN_DIV - 1);

  state_e     state_q, state_d;
  slot_e      slot_q, slot_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] hund_q, hund_d;
  logic [3:0] ten_q, ten_d;
  logic [3:0] unit_q, unit_d;
  logic       loaded_q, loaded_d;
  logic [6:0] seg_q, seg_d;
  logic [2:0] an_q, an_d;
  logic       fd_q, fd_d;
  logic [3:0] digit;
  logic       blank;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h79;
    endcase
    return code;
  endfunction

  // Capture, state and slot sequencing.
  always_comb begin
    hund_d   = hund_q;
    ten_d    = ten_q;
    unit_d   = unit_q;
    loaded_d = loaded_q;
    state_d  = state_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;

    if (bus.in_valid) begin
      hund_d   = bus.in_hundred;
      ten_d    = bus.in_ten;
      unit_d   = bus.in_unit;
      loaded_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        slot_d = SlotHund;
        cnt_d  = '0;
        // loaded_d already folds in a same-edge strobe
        if (bus.disp_en && loaded_d) state_d = StScan;
      end
      StScan: begin
        if (!bus.disp_en) begin
          state_d = StIdle;
          slot_d  = SlotHund;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          cnt_d = '0;
          case (slot_q)
            SlotHund: slot_d = SlotTen;
            SlotTen:  slot_d = SlotUnit;
            default:  slot_d = SlotHund;
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from next-state values so the registered bus shows the
  // slot and digit that apply in the coming cycle.
  always_comb begin
    seg_d = '0;
    an_d  = '0;
    fd_d  = 1'b0;
    digit = {1'b0, hund_d};
    blank = 1'b0;
    case (slot_d)
      SlotHund: begin
        digit = {1'b0, hund_d};
        blank = (hund_d == 3'd0);
      end
      SlotTen: begin
        digit = ten_d;
        blank = (hund_d == 3'd0) && (ten_d == 4'd0);
      end
      default: begin
        digit = unit_d;
        blank = 1'b0;
      end
    endcase
    if (state_d == StScan) begin
      case (slot_d)
        SlotHund: an_d = 3'b100;
        SlotTen:  an_d = 3'b010;
        default:  an_d = 3'b001;
      endcase
`ifdef BCD_SEG_BLANK_EN
      seg_d = blank ? 7'h00 : seg_code(digit);
`else
      seg_d = seg_code(digit);
`endif
      fd_d = (slot_d == SlotUnit) && (cnt_d == CntLast);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      slot_q   <= SlotHund;
      cnt_q    <= '0;
      hund_q   <= '0;
      ten_q    <= '0;
      unit_q   <= '0;
      loaded_q <= 1'b0;
      seg_q    <= '0;
      an_q     <= '0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      hund_q   <= hund_d;
      ten_q    <= ten_d;
      unit_q   <= unit_d;
      loaded_q <= loaded_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

`ifndef BCD_SEG_BLANK_EN
  // blank only feeds the blanking path
  logic unused_blank;
  assign unused_blank = blank;
`endif

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule
